// File: rtl/jpeg_block_sequencer_if.sv
// ---------------------------------------------------------------------------
// jpeg_block_sequencer_if
//
// Purpose: bundles the two streaming handshakes of the JPEG block sequencer
// (pixel input stream and coefficient output stream).
//
// Signals:
//   in_valid  / in_ready  / in_data            pixel stream into the sequencer
//   out_valid / out_ready / out_data / out_last coefficient stream out of it
//
// Modports:
//   master - environment side: pixel source plus coefficient sink
//   slave  - sequencer side
// ---------------------------------------------------------------------------
interface jpeg_block_sequencer_if #(
    parameter int DW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/jpeg_block_sequencer.sv
// ---------------------------------------------------------------------------
// jpeg_block_sequencer
//
// Purpose: sequential wrapper around the combinational 8x8 DCT + quantizer.
// Gathers 64 raster-ordered pixels into a block register that drives the
// core, waits SETTLE_CYCLES for the core to settle, snapshots its 64
// coefficients and streams them out one per handshake.
//
// Build option: JPEG_SEQ_ZIGZAG_EN
//   defined   - coefficients leave in standard JPEG zigzag order
//   undefined - coefficients leave in raster order (no zigzag ROM)
//
// Parameters:
//   DW            pixel / coefficient width
//   SETTLE_CYCLES core settle time in cycles, 1..255
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   bus        slave side of the pixel / coefficient streams
//   blk_out    registered block to core, element k at [DW*k +: DW]
//   coef_in    quantized coefficients from core, same packing
//   busy       high while settling or unloading
//   blk_count  blocks fully unloaded, wraps at 16 bits
// ---------------------------------------------------------------------------
module jpeg_block_sequencer #(
    parameter int DW            = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    jpeg_block_sequencer_if.slave bus,
    output logic [64*DW-1:0]      blk_out,
    input  logic [64*DW-1:0]      coef_in,
    output logic                  busy,
    output logic [15:0]           blk_count
);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SETTLE,
        ST_UNLOAD
    } state_e;

`ifdef JPEG_SEQ_ZIGZAG_EN
    // Raster index of the i-th coefficient in JPEG zigzag order.
    localparam logic [5:0] ZIGZAG [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };
`endif

    // Maps output position to the raster index of the coefficient sent there.
    function automatic logic [5:0] order_f(input logic [5:0] idx);
`ifdef JPEG_SEQ_ZIGZAG_EN
        return ZIGZAG[idx];
`else
        return idx;
`endif
    endfunction

    state_e                 state_q,      state_d;
    logic [5:0]             load_idx_q,   load_idx_d;
    logic [5:0]             out_idx_q,    out_idx_d;
    logic [7:0]             settle_cnt_q, settle_cnt_d;
    logic [15:0]            blk_count_q,  blk_count_d;
    // Packed so element k lands exactly at bits [DW*k +: DW] of the flat bus.
    logic [63:0][DW-1:0]    blk_q,        blk_d;
    logic [63:0][DW-1:0]    snap_q,       snap_d;

    // NOTE: every variable gets its hold value before the case statement, so
    // no path through this block can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        load_idx_d   = load_idx_q;
        out_idx_d    = out_idx_q;
        settle_cnt_d = settle_cnt_q;
        blk_count_d  = blk_count_q;
        blk_d        = blk_q;
        snap_d       = snap_q;

        unique case (state_q)
            ST_LOAD: begin
                // in_ready is constantly high here, so in_valid is the handshake.
                if (bus.in_valid) begin
                    blk_d[load_idx_q] = bus.in_data;
                    load_idx_d        = load_idx_q + 6'd1;   // wraps 63 -> 0
                    if (load_idx_q == 6'd63) begin
                        settle_cnt_d = 8'(SETTLE_CYCLES);
                        state_d      = ST_SETTLE;
                    end
                end
            end

            ST_SETTLE: begin
                settle_cnt_d = settle_cnt_q - 8'd1;
                // Snapshot on the last settle edge so out_valid rises exactly
                // SETTLE_CYCLES edges after the 64th pixel was taken.
                if (settle_cnt_q == 8'd1) begin
                    snap_d    = coef_in;
                    out_idx_d = 6'd0;
                    state_d   = ST_UNLOAD;
                end
            end

            ST_UNLOAD: begin
                if (bus.out_ready) begin
                    out_idx_d = out_idx_q + 6'd1;            // wraps 63 -> 0
                    if (out_idx_q == 6'd63) begin
                        blk_count_d = blk_count_q + 16'd1;
                        state_d     = ST_LOAD;
                    end
                end
            end

            default: state_d = ST_LOAD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_LOAD;
            load_idx_q   <= '0;
            out_idx_q    <= '0;
            settle_cnt_q <= '0;
            blk_count_q  <= '0;
            // NOTE: block and snapshot storage is cleared on reset on purpose:
            // the core sees a known all-zero block and out_data reads 0.
            blk_q        <= '0;
            snap_q       <= '0;
        end else begin
            state_q      <= state_d;
            load_idx_q   <= load_idx_d;
            out_idx_q    <= out_idx_d;
            settle_cnt_q <= settle_cnt_d;
            blk_count_q  <= blk_count_d;
            blk_q        <= blk_d;
            snap_q       <= snap_d;
        end
    end

    // All outputs decode registers only; out_ready never reaches out_data.
    assign bus.in_ready  = (state_q == ST_LOAD);
    assign bus.out_valid = (state_q == ST_UNLOAD);
    assign bus.out_last  = (state_q == ST_UNLOAD) && (out_idx_q == 6'd63);
    assign bus.out_data  = snap_q[order_f(out_idx_q)];
    assign busy          = (state_q != ST_LOAD);
    assign blk_count     = blk_count_q;
    assign blk_out       = blk_q;

endmodule

// File: tb/tb_jpeg_block_sequencer.sv
// ---------------------------------------------------------------------------
// tb_jpeg_block_sequencer
//
// Directed bench for jpeg_block_sequencer. The main instance uses
// SETTLE_CYCLES=4 with coef_in looped back from blk_out (or overridden); a
// second instance with SETTLE_CYCLES=1 covers the minimum settle latency.
// Expected output order follows JPEG_SEQ_ZIGZAG_EN as built.
// ---------------------------------------------------------------------------
module tb_jpeg_block_sequencer;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    jpeg_block_sequencer_if #(.DW(DW)) bus  ();
    jpeg_block_sequencer_if #(.DW(DW)) bus1 ();

    logic [64*DW-1:0]    blk_out, blk_out1, coef_in;
    logic                busy, busy1;
    logic [15:0]         blk_count, blk_count1;
    logic                use_ovr;
    logic [63:0][DW-1:0] coef_ovr;

    assign coef_in = use_ovr ? coef_ovr : blk_out;

    jpeg_block_sequencer #(.DW(DW), .SETTLE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .blk_out(blk_out), .coef_in(coef_in),
        .busy(busy), .blk_count(blk_count)
    );

    jpeg_block_sequencer #(.DW(DW), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .blk_out(blk_out1), .coef_in(blk_out1),
        .busy(busy1), .blk_count(blk_count1)
    );

`ifdef JPEG_SEQ_ZIGZAG_EN
    int zz [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };
`endif

    function automatic int exp_order(input int i);
`ifdef JPEG_SEQ_ZIGZAG_EN
        return zz[i];
`else
        return i;
`endif
    endfunction

    int             n_cmp = 0;
    int             n_err = 0;
    logic [DW-1:0]  src_pix  [64];   // pixels driven in
    logic [DW-1:0]  src_vals [64];   // raster coefficients the core presents
    logic [3:0]     stall_pat = 4'b1001;   // out_ready per cycle: 1,0,0,1

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Drives the first n entries of src_pix; optional random idle gaps.
    task automatic send_pixels(input int n, input int gap_max);
        int g;
        int t;
        for (int k = 0; k < n; k++) begin
            if (gap_max > 0) begin
                g = int'($urandom_range(gap_max, 0));
                bus.in_valid = 1'b0;
                repeat (g) step();
            end
            bus.in_valid = 1'b1;
            bus.in_data  = src_pix[k];
            t = 0;
            while (!bus.in_ready && t < 200) begin
                step();
                t++;
            end
            if (!bus.in_ready) check("in_ready_wait", 32'(bus.in_ready), 32'd1);
            step();
        end
        bus.in_valid = 1'b0;
    endtask

    // Called right after the 64th pixel edge; returns cycles until out_valid.
    task automatic wait_unload(input int switch_at, output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 300) begin
            if (lat == switch_at) use_ovr = 1'b1;
            step();
            lat++;
        end
        check("out_valid_rise", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic recv_block(input bit stall, input bit hold_in, input int exp_count);
        int rcv;
        int c;
        rcv = 0;
        c   = 0;
        if (hold_in) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'hDEAD;
        end
        while (rcv < 64 && c < 1000) begin
            bus.out_ready = stall ? stall_pat[c % 4] : 1'b1;
            if (hold_in) check("in_ready_unload", 32'(bus.in_ready), 32'd0);
            if (bus.out_valid) begin
                check("out_data", 32'(bus.out_data), 32'(src_vals[exp_order(rcv)]));
                check("out_last", 32'(bus.out_last), 32'(rcv == 63));
                if (bus.out_ready) rcv++;
            end
            step();
            c++;
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check("coef_count",      32'(rcv), 32'd64);
        check("out_valid_after", 32'(bus.out_valid), 32'd0);
        check("in_ready_after",  32'(bus.in_ready), 32'd1);
        check("blk_count",       32'(blk_count), 32'(exp_count));
    endtask

    initial begin
        int lat;

        rst = 1'b1;
        use_ovr = 1'b0;
        coef_ovr = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        bus1.in_valid = 1'b0;
        bus1.in_data = '0;
        bus1.out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_in_ready",  32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_last",  32'(bus.out_last), 32'd0);
        check("rst_out_data",  32'(bus.out_data), 32'd0);
        check("rst_busy",      32'(busy), 32'd0);
        check("rst_blk_count", 32'(blk_count), 32'd0);
        check("rst_blk_out",   32'(blk_out == '0), 32'd1);

        // Minimum settle time on the second instance
        for (int k = 0; k < 64; k++) begin
            bus1.in_valid = 1'b1;
            bus1.in_data  = 16'(k);
            step();
        end
        bus1.in_valid = 1'b0;
        lat = 0;
        while (!bus1.out_valid && lat < 20) begin
            step();
            lat++;
        end
        check("latency_s1", 32'(lat), 32'd1);
        check("s1_first",   32'(bus1.out_data), 32'd0);

        // Identity loopback, pixel k = k
        for (int k = 0; k < 64; k++) begin
            src_pix[k]  = 16'(k);
            src_vals[k] = 16'(k);
        end
        send_pixels(64, 0);
        check("settle_busy",     32'(busy), 32'd1);
        check("settle_in_ready", 32'(bus.in_ready), 32'd0);
        check("settle_valid",    32'(bus.out_valid), 32'd0);
        wait_unload(-1, lat);
        check("latency_s4", 32'(lat), 32'd4);
        check("unload_busy", 32'(busy), 32'd1);
        recv_block(1'b0, 1'b0, 1);

        // Core output changes two cycles into settle: new values are captured
        for (int k = 0; k < 64; k++) begin
            src_pix[k]  = 16'(k * 3 + 100);
            coef_ovr[k] = 16'(16'h5000 + k);
            src_vals[k] = 16'(16'h5000 + k);
        end
        send_pixels(64, 0);
        wait_unload(2, lat);
        check("latency_late_coef", 32'(lat), 32'd4);
        recv_block(1'b0, 1'b0, 2);
        use_ovr = 1'b0;

        // Backpressure 1,0,0,1 with a pixel held on the input throughout
        for (int k = 0; k < 64; k++) begin
            src_pix[k]  = 16'($urandom);
            src_vals[k] = src_pix[k];
        end
        send_pixels(64, 2);
        wait_unload(-1, lat);
        recv_block(1'b1, 1'b1, 3);

        // Reset in the middle of unloading
        for (int k = 0; k < 64; k++) begin
            src_pix[k]  = 16'(16'h0200 + k);
            src_vals[k] = src_pix[k];
        end
        send_pixels(64, 0);
        wait_unload(-1, lat);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("pre_rst_data", 32'(bus.out_data), 32'(src_vals[exp_order(i)]));
            step();
        end
        bus.out_ready = 1'b0;
        pulse_reset();
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_out_last",  32'(bus.out_last), 32'd0);
        check("midrst_blk_count", 32'(blk_count), 32'd0);
        check("midrst_in_ready",  32'(bus.in_ready), 32'd1);
        check("midrst_busy",      32'(busy), 32'd0);

        // Reset after 30 pixels, then a full block of 0x00AA
        for (int k = 0; k < 64; k++) src_pix[k] = 16'(16'h1100 + k);
        send_pixels(30, 0);
        pulse_reset();
        for (int k = 0; k < 64; k++) begin
            src_pix[k]  = 16'h00AA;
            src_vals[k] = 16'h00AA;
        end
        send_pixels(64, 0);
        wait_unload(-1, lat);
        check("latency_after_rst", 32'(lat), 32'd4);
        recv_block(1'b0, 1'b0, 1);

        // Four back-to-back random blocks with random input gaps
        pulse_reset();
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 64; k++) begin
                src_pix[k]  = 16'($urandom);
                src_vals[k] = src_pix[k];
            end
            send_pixels(64, 3);
            wait_unload(-1, lat);
            recv_block(1'b0, 1'b0, b + 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
